// File: rtl/wf_regfile_sb.sv
// Two-read/one-write register file: sequenced clear after reset, optional zero register,
// same-cycle write/busy-clear bypass and a per-register busy scoreboard. Reads are combinational.
module wf_regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] WA3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_addr,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              RD1_busy,
    output logic              RD2_busy,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                ready_q, ready_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic                run;
    logic                wr_ok;
    logic                lk_ok;

    logic [ADDR_W-1:0]   ra      [2];
    logic [DATA_W-1:0]   rd      [2];
    logic                rd_busy [2];

    assign run = (state_q == S_RUN);

    // Writes and locks to r0 are dropped when r0 is hardwired to zero.
    always_comb begin
        wr_ok = run && write_en && !(ZERO_R0 && (WA3 == '0));
        lk_ok = run && lock_en  && !(ZERO_R0 && (lock_addr == '0));
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_wa    = WA3;
        mem_wd    = WD3;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_wa    = clr_ptr_q;
            mem_wd    = '0;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end else begin
            ready_d = 1'b1;
            mem_we  = wr_ok;
            if (wr_ok) busy_d[WA3] = 1'b0;
            // Lock is applied after the write so a same-address lock wins.
            if (lk_ok) busy_d[lock_addr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign ra[0] = RA1;
    assign ra[1] = RA2;

    // Outputs are held at zero until the clear has visited every entry.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p]      = '0;
            rd_busy[p] = 1'b0;
            if (run) begin
                rd[p]      = mem_q[ra[p]];
                rd_busy[p] = busy_q[ra[p]];
                if (BYPASS && wr_ok && (WA3 == ra[p])) begin
                    rd[p]      = WD3;
                    rd_busy[p] = lk_ok && (lock_addr == ra[p]);
                end
                if (ZERO_R0 && (ra[p] == '0)) begin
                    rd[p]      = '0;
                    rd_busy[p] = 1'b0;
                end
            end
        end
    end

    assign RD1      = rd[0];
    assign RD2      = rd[1];
    assign RD1_busy = rd_busy[0];
    assign RD2_busy = rd_busy[1];
    assign ready    = ready_q;

endmodule

// File: tb/tb_wf_regfile_sb.sv
// Directed bench: default instance (ZERO_R0=1, BYPASS=1) and an alternate (ZERO_R0=0, BYPASS=0) share stimulus.
module tb_wf_regfile_sb;

    logic        CLK;
    logic        RST;
    logic        write_en;
    logic [4:0]  WA3;
    logic [31:0] WD3;
    logic        lock_en;
    logic [4:0]  lock_addr;
    logic [4:0]  RA1;
    logic [4:0]  RA2;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        b1_a, b2_a, b1_b, b2_b;
    logic        rdy_a, rdy_b;

    int tests;
    int fails;

    wf_regfile_sb dut (
        .CLK(CLK), .RST(RST), .write_en(write_en), .WA3(WA3), .WD3(WD3),
        .lock_en(lock_en), .lock_addr(lock_addr), .RA1(RA1), .RA2(RA2),
        .RD1(rd1_a), .RD2(rd2_a), .RD1_busy(b1_a), .RD2_busy(b2_a), .ready(rdy_a)
    );

    wf_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_alt (
        .CLK(CLK), .RST(RST), .write_en(write_en), .WA3(WA3), .WD3(WD3),
        .lock_en(lock_en), .lock_addr(lock_addr), .RA1(RA1), .RA2(RA2),
        .RD1(rd1_b), .RD2(rd2_b), .RD1_busy(b1_b), .RD2_busy(b2_b), .ready(rdy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        write_en  = 1'b0;
        lock_en   = 1'b0;
        WA3       = '0;
        WD3       = '0;
        lock_addr = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        RA1 = 5'd4;
        RA2 = 5'd4;
        repeat (3) step();
        tests++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || rd1_a !== 32'h0 || b1_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_state ready=%b/%b rd1=%h busy=%b want ready=0 rd1=0 busy=0",
                     rdy_a, rdy_b, rd1_a, b1_a);
        end
        RST = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tests++;
            if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
                fails++;
                $display("FAIL clear_ready_low cycle %0d ready=%b/%b want 0", i, rdy_a, rdy_b);
            end
            step();
        end
        tests++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            fails++;
            $display("FAIL clear_ready_high cycle 33 ready=%b/%b want 1", rdy_a, rdy_b);
        end
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i);
            RA2 = 5'(31 - i);
            #1;
            tests++;
            if (rd1_a !== 32'h0 || rd2_a !== 32'h0 || b1_a !== 1'b0 || b2_a !== 1'b0 ||
                rd1_b !== 32'h0 || rd2_b !== 32'h0 || b1_b !== 1'b0 || b2_b !== 1'b0) begin
                fails++;
                $display("FAIL cleared_read addr %0d rd=%h %h %h %h busy=%b%b%b%b want all 0",
                         i, rd1_a, rd2_a, rd1_b, rd2_b, b1_a, b2_a, b1_b, b2_b);
            end
        end
    endtask

    task automatic test_mid_clear();
        RST = 1'b1;
        step();
        RST       = 1'b0;
        write_en  = 1'b1;
        WA3       = 5'd3;
        WD3       = 32'hDEADBEEF;
        lock_en   = 1'b1;
        lock_addr = 5'd3;
        repeat (10) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tests++;
            if (rdy_a !== 1'b0) begin
                fails++;
                $display("FAIL midclear_ready_low cycle %0d ready=%b want 0", i, rdy_a);
            end
            step();
        end
        tests++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            fails++;
            $display("FAIL midclear_ready_high ready=%b/%b want 1", rdy_a, rdy_b);
        end
        idle_inputs();
        RA1 = 5'd3;
        RA2 = 5'd3;
        #1;
        tests++;
        if (rd1_a !== 32'h0 || b1_a !== 1'b0 || rd2_b !== 32'h0 || b2_b !== 1'b0) begin
            fails++;
            $display("FAIL clear_write_ignored rd=%h/%h busy=%b/%b want 0", rd1_a, rd2_b, b1_a, b2_b);
        end
    endtask

    task automatic test_bypass();
        write_en = 1'b1;
        WA3      = 5'd7;
        WD3      = 32'h12345678;
        RA1      = 5'd7;
        #1;
        tests++;
        if (rd1_a !== 32'h12345678) begin
            fails++;
            $display("FAIL bypass_same_cycle rd1=%h want 12345678", rd1_a);
        end
        tests++;
        if (rd1_b !== 32'h0) begin
            fails++;
            $display("FAIL nobypass_same_cycle rd1=%h want 00000000", rd1_b);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (rd1_a !== 32'h12345678 || rd1_b !== 32'h12345678) begin
            fails++;
            $display("FAIL write_next_cycle rd1=%h/%h want 12345678", rd1_a, rd1_b);
        end
    endtask

    task automatic test_zero_reg();
        write_en  = 1'b1;
        WA3       = 5'd0;
        WD3       = 32'hFFFFFFFF;
        lock_en   = 1'b1;
        lock_addr = 5'd0;
        RA1       = 5'd0;
        #1;
        tests++;
        if (rd1_a !== 32'h0 || b1_a !== 1'b0) begin
            fails++;
            $display("FAIL zero_same_cycle rd1=%h busy=%b want 0/0", rd1_a, b1_a);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (rd1_a !== 32'h0 || b1_a !== 1'b0) begin
            fails++;
            $display("FAIL zero_after rd1=%h busy=%b want 0/0", rd1_a, b1_a);
        end
        tests++;
        if (rd1_b !== 32'hFFFFFFFF || b1_b !== 1'b1) begin
            fails++;
            $display("FAIL nonzero_r0 rd1=%h busy=%b want ffffffff/1", rd1_b, b1_b);
        end
    endtask

    task automatic test_scoreboard();
        lock_en   = 1'b1;
        lock_addr = 5'd5;
        RA2       = 5'd5;
        #1;
        tests++;
        if (b2_a !== 1'b0 || b2_b !== 1'b0) begin
            fails++;
            $display("FAIL lock_not_early busy=%b/%b want 0", b2_a, b2_b);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (b2_a !== 1'b1 || b2_b !== 1'b1) begin
            fails++;
            $display("FAIL lock_visible busy=%b/%b want 1", b2_a, b2_b);
        end
        write_en = 1'b1;
        WA3      = 5'd5;
        WD3      = 32'h000000A5;
        #1;
        tests++;
        if (rd2_a !== 32'hA5 || b2_a !== 1'b0 || rd2_b !== 32'h0 || b2_b !== 1'b1) begin
            fails++;
            $display("FAIL unlock_same_cycle rd2=%h/%h busy=%b/%b want a5/0 0/1", rd2_a, rd2_b, b2_a, b2_b);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (rd2_a !== 32'hA5 || b2_a !== 1'b0 || rd2_b !== 32'hA5 || b2_b !== 1'b0) begin
            fails++;
            $display("FAIL unlock_after rd2=%h/%h busy=%b/%b want a5/0", rd2_a, rd2_b, b2_a, b2_b);
        end
        write_en  = 1'b1;
        WA3       = 5'd5;
        WD3       = 32'h0000005A;
        lock_en   = 1'b1;
        lock_addr = 5'd5;
        #1;
        tests++;
        if (rd2_a !== 32'h5A || b2_a !== 1'b1 || rd2_b !== 32'hA5 || b2_b !== 1'b0) begin
            fails++;
            $display("FAIL wr_lock_same_cycle rd2=%h/%h busy=%b/%b want 5a/1 a5/0", rd2_a, rd2_b, b2_a, b2_b);
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (rd2_a !== 32'h5A || b2_a !== 1'b1 || rd2_b !== 32'h5A || b2_b !== 1'b1) begin
            fails++;
            $display("FAIL wr_lock_after rd2=%h/%h busy=%b/%b want 5a/1", rd2_a, rd2_b, b2_a, b2_b);
        end
        write_en  = 1'b1;
        WA3       = 5'd6;
        WD3       = 32'h00000011;
        lock_en   = 1'b1;
        lock_addr = 5'd8;
        step();
        idle_inputs();
        RA1 = 5'd6;
        RA2 = 5'd8;
        #1;
        tests++;
        if (rd1_a !== 32'h11 || b1_a !== 1'b0 || b2_a !== 1'b1 || rd1_b !== 32'h11 || b2_b !== 1'b1) begin
            fails++;
            $display("FAIL wr_lock_diff rd1=%h/%h busy1=%b busy2=%b/%b want 11/0 1",
                     rd1_a, rd1_b, b1_a, b2_a, b2_b);
        end
    endtask

    task automatic test_dual_port();
        write_en = 1'b1;
        WA3      = 5'd9;
        WD3      = 32'h0BADF00D;
        step();
        idle_inputs();
        RA1 = 5'd9;
        RA2 = 5'd9;
        #1;
        tests++;
        if (rd1_a !== 32'h0BADF00D || rd2_a !== 32'h0BADF00D ||
            rd1_b !== 32'h0BADF00D || rd2_b !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL dual_port rd=%h %h %h %h want 0badf00d", rd1_a, rd2_a, rd1_b, rd2_b);
        end
        lock_en   = 1'b1;
        lock_addr = 5'd9;
        step();
        idle_inputs();
        #1;
        tests++;
        if (b1_a !== 1'b1 || b2_a !== 1'b1 || b1_b !== 1'b1 || b2_b !== 1'b1) begin
            fails++;
            $display("FAIL dual_busy busy=%b%b%b%b want 1111", b1_a, b2_a, b1_b, b2_b);
        end
        RST = 1'b1;
        #1;
        tests++;
        if (rdy_a !== 1'b1) begin
            fails++;
            $display("FAIL run_rst_before_edge ready=%b want 1", rdy_a);
        end
        step();
        tests++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || b1_a !== 1'b0 || rd1_a !== 32'h0) begin
            fails++;
            $display("FAIL run_rst_drop ready=%b/%b busy=%b rd1=%h want 0", rdy_a, rdy_b, b1_a, rd1_a);
        end
        RST = 1'b0;
        repeat (32) step();
        tests++;
        if (rdy_a !== 1'b1 || rd1_a !== 32'h0 || b1_a !== 1'b0 || rd2_b !== 32'h0 || b2_b !== 1'b0) begin
            fails++;
            $display("FAIL reclear ready=%b rd=%h/%h busy=%b/%b want 1 0 0", rdy_a, rd1_a, rd2_b, b1_a, b2_b);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST   = 1'b1;
        RA1   = '0;
        RA2   = '0;
        idle_inputs();
        test_reset();
        test_mid_clear();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_dual_port();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
